// File: rtl/tdm_demux.sv
// tdm_demux: splits a round-robin TDM valid/ready stream into per-channel one-entry holding registers.
// Build macro TDM_DEMUX_ERR_CNT_EN adds a saturating 8-bit frame-error counter on port err_count.
module tdm_demux #(
   parameter int unsigned N_CH = 4,
   parameter int unsigned W    = 8,
   localparam int unsigned CW  = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_data,
   input  logic              in_sof,
   output logic [N_CH-1:0]   out_valid,
   input  logic [N_CH-1:0]   out_ready,
   output logic [N_CH*W-1:0] out_data,
   output logic [CW-1:0]     cur_ch,
   output logic              frame_err
`ifdef TDM_DEMUX_ERR_CNT_EN
   ,
   output logic [7:0]        err_count
`endif
);

   logic [CW-1:0]   cnt;
   logic [CW-1:0]   tgt;
   logic [N_CH-1:0] full;
   logic            accept;
   logic            wrap;

   // SOF always lands on channel 0, even when the counter disagrees
   assign tgt      = in_sof ? '0 : cnt;
   assign in_ready = !full[tgt] || out_ready[tgt];
   assign accept   = in_valid && in_ready;
   assign wrap     = (tgt == CW'(N_CH - 1));

   assign out_valid = full;
   assign cur_ch    = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= accept && in_sof && (cnt != '0);
         if (accept) begin
            cnt <= wrap ? '0 : tgt + CW'(1);
         end
      end
   end

   // A write in the same cycle as a drain keeps the entry full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (accept && (tgt == CW'(i))) begin
               full[i] <= 1'b1;
            end else if (out_ready[i]) begin
               full[i] <= 1'b0;
            end
         end
      end
   end

   // Payload registers carry no reset; full qualifies them
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (accept && (tgt == CW'(i))) begin
            out_data[i*W +: W] <= in_data;
         end
      end
   end

`ifdef TDM_DEMUX_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= 8'd0;
      end else if (frame_err && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`endif

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive-side demultiplexer for a round-robin time-division stream. A single valid/ready input carries beats for `N_CH` channels in fixed order 0, 1, …, `N_CH`-1, with a start-of-frame marker on channel 0. The block routes each beat into a one-entry holding register for its channel and presents every channel on its own valid/ready output. It sits at the far end of a mux-based serializer and restores the per-channel streams.

## Interface
- `N_CH`, default 4: number of channels; legal range 2..16, not required to be a power of two.
- `W`, default 8: data width per beat.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  an input beat is present.
- `in_ready`  output  1  the block accepts the beat this cycle.
- `in_data`  input  W  beat payload.
- `in_sof`  input  1  start of frame; qualified by `in_valid`; the beat belongs to channel 0.
- `out_valid`  output  N_CH  per-channel holding register is full.
- `out_ready`  input  N_CH  per-channel consumer ready.
- `out_data`  output  N_CH*W  channel i is bits [i*W +: W].
- `cur_ch`  output  $clog2(N_CH)  channel index expected for the next non-SOF beat.
- `frame_err`  output  1  one-cycle pulse on a misaligned SOF.

## Operation
- State:
  - channel counter `cnt`, range 0..N_CH-1;
  - per channel, a `full` bit and a W-bit data register.
- Target channel: `tgt = in_sof ? 0 : cnt`.
- Acceptance: `in_ready = !full[tgt] || out_ready[tgt]`, combinational. A beat is accepted when `in_valid && in_ready`.
- On accept:
  - `data[tgt] <= in_data` and `full[tgt] <= 1`;
  - `cnt <= (tgt == N_CH-1) ? 0 : tgt + 1`.
- Drain: when `full[i] && out_ready[i]` and channel i is not written that cycle, `full[i] <= 0`.
- Simultaneous drain and write on one channel: data is replaced and `full` stays 1. This gives full throughput of one beat per cycle.
- `out_valid[i] = full[i]` and `out_data` slice i equals `data[i]`. Both come straight from registers.
- `cur_ch = cnt`.
- SOF check: an accepted beat with `in_sof=1` while `cnt != 0` pulses `frame_err` for one cycle. The beat still goes to channel 0, and `cnt` resyncs to 1.
  - SOF with `cnt == 0` is normal.
  - A frame without SOF is legal; the counter simply keeps rotating.
- Stall: while the target channel is full and its `out_ready` is 0, `in_ready=0`. `cnt` holds and no other channel is written. Head-of-line blocking is intended.
- `in_valid=0`: no state change except drains.
- `in_data`/`in_sof` are don't-care when `in_valid=0`.

## Timing
- Reset (`rst_n=0`, asynchronous) forces:
  - `cnt=0`;
  - all `full=0`, so `out_valid=0`;
  - `frame_err=0` and `cur_ch=0`.
- Data registers are not reset.
- Reset asserted mid-operation discards all buffered beats immediately, without waiting for a clock edge.
- First edge after reset release behaves normally.
- Latency: a beat accepted at edge k appears on `out_valid`/`out_data` after edge k, i.e. one cycle.
- `frame_err` asserts in the cycle after the offending accept, for exactly one cycle.
- `in_ready` depends combinationally on `out_ready`, `in_sof` and `in_valid`-independent state. `in_ready` must not depend on `in_valid`.
- Handshake rules:
  - Output side: the producer holds `out_valid`/`out_data` stable until taken.
  - Input side: the upstream must hold the beat while `in_ready=0`.

## Configuration
- `TDM_DEMUX_ERR_CNT_EN`:
  - When defined, adds output port `err_count` (8 bits). It resets to 0, increments on each `frame_err` pulse, and saturates at 255.
  - When undefined, the port and its counter are absent, and `frame_err` behaviour is unchanged.

## Test plan
- Reset: hold `rst_n=0` with `in_valid=1` -> `in_ready` ignored, `out_valid=0000`, `cur_ch=0`. After release, send 0xA0 with SOF -> `out_valid=0001` and `out_data[7:0]=0xA0` one cycle later, `cur_ch=1`.
- Full-rate frame: `out_ready=1111`, beats 0x10..0x13 with SOF on first, back-to-back -> each channel i shows 0x10+i one cycle after its beat. `in_ready` stays 1, `cur_ch` wraps 3->0, `frame_err` stays 0.
- Backpressure: `out_ready[2]=0`, send two frames -> the second beat for channel 2 stalls with `in_ready=0` and `cur_ch=2`. Raising `out_ready[2]` for one cycle accepts it the same cycle and channel 2 shows the new data.
- Misaligned SOF: after beats to ch0, ch1, send SOF beat 0x55 -> `frame_err` pulses once, channel 0 holds 0x55, `cur_ch=1`. With `TDM_DEMUX_ERR_CNT_EN`, `err_count` goes 0->1; after 300 misaligned SOFs it reads 255.
- Async reset mid-stream: assert `rst_n=0` between edges with channels 1 and 3 full -> `out_valid=0000` and `cur_ch=0` immediately, before the next edge.
- Non-power-of-two: `N_CH=3`, six beats, no SOF -> channel order 0,1,2,0,1,2, `cur_ch` never reaches 3.
